// File: rtl/dct_row_sequencer.sv
// Serial-to-row sequencer feeding the 8-point DCT butterfly stage.
// Applies the JPEG level shift and ping-pong buffers rows across two banks.
module dct_row_sequencer #(
  parameter int WIDTH       = 8,
  parameter bit LEVEL_SHIFT = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [WIDTH-1:0]        In_Data,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic signed [WIDTH-1:0] Out_Pixel_0,
  output logic signed [WIDTH-1:0] Out_Pixel_1,
  output logic signed [WIDTH-1:0] Out_Pixel_2,
  output logic signed [WIDTH-1:0] Out_Pixel_3,
  output logic signed [WIDTH-1:0] Out_Pixel_4,
  output logic signed [WIDTH-1:0] Out_Pixel_5,
  output logic signed [WIDTH-1:0] Out_Pixel_6,
  output logic signed [WIDTH-1:0] Out_Pixel_7,
  output logic [2:0]              Out_Row,
  output logic                    Out_Block_Last
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t      st     [2];
  bank_state_t      st_nxt [2];
  logic [WIDTH-1:0] bank   [2][8];

  logic             wr, rd, wr_nxt, rd_nxt;
  logic [2:0]       col, row;
  logic             in_fire, out_fire;
  logic             ready_nxt, valid_nxt;
  logic [WIDTH-1:0] cap;

  // The draining bank is always FULL and the filling bank never is, so the two
  // updates below never target the same bank.
  always_comb begin
    in_fire   = In_Valid && In_Ready;
    out_fire  = Out_Valid && Out_Ready;
    cap       = In_Data;
    if (LEVEL_SHIFT) cap[WIDTH-1] = ~In_Data[WIDTH-1];
    st_nxt[0] = st[0];
    st_nxt[1] = st[1];
    wr_nxt    = wr;
    rd_nxt    = rd;
    if (out_fire) begin
      st_nxt[rd] = EMPTY;
      rd_nxt     = ~rd;
    end
    if (in_fire) begin
      if (col == 3'd7) begin
        st_nxt[wr] = FULL;
        wr_nxt     = ~wr;
      end else begin
        st_nxt[wr] = FILLING;
      end
    end
    ready_nxt = (st_nxt[wr_nxt] != FULL);
    valid_nxt = (st_nxt[rd_nxt] == FULL);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      st[0]     <= EMPTY;
      st[1]     <= EMPTY;
      wr        <= 1'b0;
      rd        <= 1'b0;
      col       <= '0;
      row       <= '0;
      In_Ready  <= 1'b0;
      Out_Valid <= 1'b0;
    end else begin
      st[0]     <= st_nxt[0];
      st[1]     <= st_nxt[1];
      wr        <= wr_nxt;
      rd        <= rd_nxt;
      In_Ready  <= ready_nxt;
      Out_Valid <= valid_nxt;
      if (in_fire)  col <= col + 3'd1;
      if (out_fire) row <= row + 3'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned k = 0; k < 8; k++) begin
          bank[b][k] <= '0;
        end
      end
    end else if (in_fire) begin
      bank[wr][col] <= cap;
    end
  end

  assign Out_Pixel_0    = bank[rd][0];
  assign Out_Pixel_1    = bank[rd][1];
  assign Out_Pixel_2    = bank[rd][2];
  assign Out_Pixel_3    = bank[rd][3];
  assign Out_Pixel_4    = bank[rd][4];
  assign Out_Pixel_5    = bank[rd][5];
  assign Out_Pixel_6    = bank[rd][6];
  assign Out_Pixel_7    = bank[rd][7];
  assign Out_Row        = row;
  assign Out_Block_Last = (row == 3'd7);

endmodule
